// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its FIFOs.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO with synchronous clear and a zero-latency head read.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers alone
  // decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential RV32I fetch: issues in-order imem requests under a credit limit,
// buffers returned words with their PC, and flushes on redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_addr_out,
  input  logic        imem_resp_valid_in,
  input  logic [31:0] imem_resp_data_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        instr_ready_in
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t     ififo_wdata, ififo_rdata;
  logic [CNT_W-1:0] ififo_count;
  logic             ififo_full, ififo_empty, ififo_push, ififo_pop;

  logic [XLEN-1:0]  resp_pc;
  logic [OUT_W-1:0] pcq_count;
  logic             pcq_full, pcq_empty;

  logic             credit_ok, slot_ok, req_fire, resp_fire;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_in[1:0];

  // Buffered plus in-flight words never exceed DEPTH, so a response always has room.
  assign credit_ok = (32'(ififo_count) + 32'(outstanding_q)) < 32'(DEPTH);
  assign slot_ok   = 32'(outstanding_q) < 32'(MAX_OUTSTANDING);

  assign imem_req_valid_out = !reset && !redirect_valid_in && slot_ok && credit_ok;
  assign imem_addr_out      = fetch_pc_q;
  assign req_fire           = imem_req_valid_out && imem_req_ready_in;
  assign resp_fire          = imem_resp_valid_in;

  assign ififo_push        = resp_fire && (drop_cnt_q == '0) && !redirect_valid_in;
  assign ififo_pop         = instr_valid_out && instr_ready_in && !redirect_valid_in;
  assign ififo_wdata.pc    = resp_pc;
  assign ififo_wdata.instr = imem_resp_data_in;

  assign instr_valid_out = !ififo_empty;
  assign instr_out       = ififo_empty ? '0 : ififo_rdata.instr;
  assign pc_out          = ififo_empty ? '0 : ififo_rdata.pc;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path can infer a latch.
  always_comb begin
    outstanding_d = outstanding_q;
    fetch_pc_d    = fetch_pc_q;
    drop_cnt_d    = drop_cnt_q;

    if (req_fire && !resp_fire) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!req_fire && resp_fire) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end

    if (redirect_valid_in) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = {redirect_pc_in[31:2], 2'b00};
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_fire && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC_ALIGNED;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect_valid_in),
    .push_i  (ififo_push),
    .wdata_i (ififo_wdata),
    .pop_i   (ififo_pop),
    .rdata_o (ififo_rdata),
    .full_o  (ififo_full),
    .empty_o (ififo_empty),
    .count_o (ififo_count)
  );

  // Not cleared on redirect: it drains in step with the dropped responses.
  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (XLEN)
  ) u_pc_queue (
    .clk     (clk),
    .reset   (reset),
    .clear_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (resp_fire),
    .rdata_o (resp_pc),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (resp_fire && drop_cnt_q == '0) |-> !ififo_full);
  a_resp_has_pc: assert property (@(posedge clk) disable iff (reset)
    resp_fire |-> !pcq_empty);
  a_req_has_slot: assert property (@(posedge clk) disable iff (reset)
    req_fire |-> !pcq_full);
  a_pcq_tracks: assert property (@(posedge clk) disable iff (reset)
    pcq_count == outstanding_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench: a queue-based memory/stream model predicts every output
// of the main instance; a second instance checks PC wrap-around from a high RESET_PC.
module tb_instr_fetch_unit;

  localparam logic [31:0] MAIN_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;
  localparam int          DEPTH   = 4;
  localparam int          MAXO    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req_valid_out, imem_req_ready_in;
  logic [31:0] imem_addr_out;
  logic        imem_resp_valid_in;
  logic [31:0] imem_resp_data_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        instr_valid_out, instr_ready_in;
  logic [31:0] instr_out, pc_out;

  logic        w_req_valid, w_req_ready, w_resp_valid, w_redirect, w_valid, w_ready;
  logic [31:0] w_addr, w_resp_data, w_redirect_pc, w_instr, w_pc;

  instr_fetch_unit #(.RESET_PC(MAIN_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_addr_out      (imem_addr_out),
    .imem_resp_valid_in (imem_resp_valid_in),
    .imem_resp_data_in  (imem_resp_data_in),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_pc_in     (redirect_pc_in),
    .instr_valid_out    (instr_valid_out),
    .instr_out          (instr_out),
    .pc_out             (pc_out),
    .instr_ready_in     (instr_ready_in)
  );

  instr_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut_wrap (
    .clk                (clk),
    .reset              (reset),
    .imem_req_valid_out (w_req_valid),
    .imem_req_ready_in  (w_req_ready),
    .imem_addr_out      (w_addr),
    .imem_resp_valid_in (w_resp_valid),
    .imem_resp_data_in  (w_resp_data),
    .redirect_valid_in  (w_redirect),
    .redirect_pc_in     (w_redirect_pc),
    .instr_valid_out    (w_valid),
    .instr_out          (w_instr),
    .pc_out             (w_pc),
    .instr_ready_in     (w_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem_q[$];     // accepted requests awaiting response
  logic [31:0] fifo_q[$];    // PCs the decoder should see, in order
  int          epoch, cyc, lat;
  logic [31:0] exp_addr;
  logic        started, last_rst;
  logic        last_pop;
  logic [31:0] last_pop_pc;

  logic [31:0] w_exp, w_pend_addr;
  logic        w_pend;

  int n_vec, n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic dec_rdy, input logic mem_rdy);
    logic        m_resp, m_req, m_valid, accept, pop, deliver, w_acc;
    logic [31:0] w_addr_s;
    req_t        h, nr;
    @(negedge clk);
    reset              = rst;
    m_resp             = !rst && mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_resp_valid_in = m_resp;
    imem_resp_data_in  = m_resp ? (mem_q[0].addr ^ XOR_PAT) : 32'hDEAD_BEEF;
    redirect_valid_in  = redir && !rst;
    redirect_pc_in     = rpc;
    instr_ready_in     = dec_rdy;
    imem_req_ready_in  = mem_rdy;
    w_resp_valid       = w_pend && !rst;
    w_resp_data        = w_pend_addr ^ XOR_PAT;
    #1;
    m_req   = !rst && !redir && mem_q.size() < MAXO && (fifo_q.size() + mem_q.size()) < DEPTH;
    m_valid = fifo_q.size() > 0;
    if (started) begin
      check("req_valid", 32'(imem_req_valid_out), 32'(m_req));
      check("imem_addr", imem_addr_out, exp_addr);
      check("instr_valid", 32'(instr_valid_out), 32'(m_valid));
      if (m_valid) begin
        check("pc_out", pc_out, fifo_q[0]);
        check("instr_out", instr_out, fifo_q[0] ^ XOR_PAT);
      end else if (last_rst) begin
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_instr_out", instr_out, 32'h0);
      end
      if (w_valid === 1'b1) begin
        check("wrap_pc", w_pc, w_exp);
        check("wrap_instr", w_instr, w_exp ^ XOR_PAT);
      end
    end
    last_pop    = started && (instr_valid_out === 1'b1) && dec_rdy && !redir && !rst;
    last_pop_pc = pc_out;
    w_acc       = (w_req_valid === 1'b1);
    w_addr_s    = w_addr;
    accept      = m_req && mem_rdy;
    pop         = m_valid && dec_rdy;
    @(posedge clk);
    if (rst) begin
      mem_q.delete();
      fifo_q.delete();
      exp_addr = MAIN_PC;
      w_exp    = WRAP_PC;
      w_pend   = 1'b0;
      started  = 1'b1;
      last_rst = 1'b1;
    end else begin
      last_rst = 1'b0;
      deliver  = 1'b0;
      if (m_resp) begin
        h       = mem_q.pop_front();
        deliver = !redir && (h.epoch == epoch);
      end
      if (redir) begin
        fifo_q.delete();
        epoch++;
        exp_addr = {rpc[31:2], 2'b00};
      end else begin
        if (pop) void'(fifo_q.pop_front());
        if (deliver) fifo_q.push_back(h.addr);
        if (accept) begin
          nr.addr  = exp_addr;
          nr.epoch = epoch;
          nr.due   = cyc + lat;
          mem_q.push_back(nr);
          exp_addr += 32'd4;
        end
      end
      if (started && w_valid === 1'b1) w_exp += 32'd4;
      w_pend      = w_acc;
      w_pend_addr = w_addr_s;
    end
    cyc++;
  endtask

  initial begin
    logic found;
    n_vec = 0; n_err = 0; cyc = 0; epoch = 0; lat = 1;
    started = 1'b0; last_rst = 1'b0; last_pop = 1'b0; last_pop_pc = '0;
    exp_addr = MAIN_PC; w_exp = WRAP_PC; w_pend = 1'b0; w_pend_addr = '0;
    reset = 1'b1; imem_req_ready_in = 1'b0; imem_resp_valid_in = 1'b0;
    imem_resp_data_in = '0; redirect_valid_in = 1'b0; redirect_pc_in = '0;
    instr_ready_in = 1'b0;
    w_req_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0; w_ready = 1'b1;
    w_resp_valid = 1'b0; w_resp_data = '0;

    repeat (3) step(1'b1, 1'b0, '0, 1'b1, 1'b1);

    // Streaming with a 1-cycle memory, then decoder backpressure and release.
    repeat (20) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      if (last_pop) begin
        check("first_after_redirect", last_pop_pc, 32'h0000_0100);
        found = 1'b1;
      end
    end
    if (!found) check("redirect_timeout", 32'(found), 32'h1);
    repeat (6) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Redirect coincident with a response and a pop while entries are buffered.
    lat = 1;
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Reset with words buffered and a request outstanding.
    lat = 2;
    for (int i = 0; i < 20 && !(fifo_q.size() == 3 && mem_q.size() == 1); i++)
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    lat = 1;
    repeat (10) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Random traffic: latency, readiness, redirects and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) lat = int'($urandom_range(1, 4));
      step($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer end of the decoder's instruction interface: generates sequential RV32I fetch addresses and issues in-order requests to instruction memory.
- Buffers returned 32-bit words in a small FIFO and presents them, with their PC, to the control unit under a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0.
- DEPTH, 4, instruction FIFO entries; power of two, 2..16; also the cap on buffered plus in-flight fetches.
- MAX_OUTSTANDING, 2, maximum accepted imem requests awaiting response; 1..DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid_out  out  1  fetch request valid.
- imem_req_ready_in  in  1  memory accepts request.
- imem_addr_out  out  32  word-aligned fetch address.
- imem_resp_valid_in  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
- imem_resp_data_in  in  32  fetched instruction word.
- redirect_valid_in  in  1  single-cycle redirect pulse.
- redirect_pc_in  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- instr_valid_out  out  1  FIFO head valid toward the decoder.
- instr_out  out  32  instruction word; feeds the decoder's instr_in.
- pc_out  out  32  PC of instr_out.
- instr_ready_in  in  1  decoder consumes the head this cycle.

Behaviour:
- Reset (clk edge with reset=1):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - All outputs low or 0 in the cycle after the reset edge, except imem_addr_out=RESET_PC.
  - Reset overrides redirect and any handshake in the same cycle.
  - Responses arriving after reset that belong to pre-reset requests are the memory's responsibility; the memory is reset together with this block.
- Request issue (combinational):
  - imem_req_valid_out = !redirect_valid_in && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding)<DEPTH.
  - imem_addr_out=fetch_pc.
  - On accept (valid && ready): fetch_pc+=4 with 32-bit wrap (FFFF_FFFC -> 0000_0000); outstanding+=1.
  - The PC of each accepted request is pushed into an internal in-flight PC queue (MAX_OUTSTANDING entries).
- Response handling:
  - On imem_resp_valid_in, outstanding-=1 and the in-flight PC queue is popped.
  - If drop_cnt>0: the word is discarded and drop_cnt-=1.
  - Otherwise {popped PC, data} is written to the FIFO in the same edge.
  - The credit rule guarantees the FIFO cannot overflow. A response arriving with FIFO full and drop_cnt=0 is an assertion failure.
- Output:
  - instr_valid_out = !fifo_empty; instr_out/pc_out come from the FIFO head (zero-latency head read).
  - Pop when instr_valid_out && instr_ready_in.
  - instr_out/pc_out hold stable while valid && !ready.
  - Simultaneous push and pop on a full or empty FIFO is legal: count is unchanged when full; data bypasses through storage with one-cycle latency when empty (no combinational path from resp to instr_out).
- Redirect (redirect_valid_in=1):
  - FIFO cleared, and any pop in the same cycle is ignored.
  - fetch_pc={redirect_pc_in[31:2],2'b00}; no request issued that cycle.
  - drop_cnt = outstanding_next, i.e. outstanding minus 1 if a response arrives this same cycle. That response is itself discarded.
  - The in-flight PC queue is not cleared; it drains with the dropped responses.
  - Fetching resumes the next cycle. The first instruction can appear on instr_valid_out no earlier than 2 cycles after the request is accepted.
  - Back-to-back redirects: the latest one wins; drop_cnt is recomputed each time.
- Latency:
  - Best case is request accept at cycle N, response at N+1, instr_valid_out at N+2.
  - Sustained throughput is 1 instruction/cycle with a 1-cycle memory and MAX_OUTSTANDING>=2.
- Counters: outstanding and drop_cnt are $clog2(MAX_OUTSTANDING+1) bits; fifo_count is $clog2(DEPTH+1) bits.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32 and XLEN=32.
  - NOP_INSTR=32'h0000_0013 (addi x0,x0,0).
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo, parameterized DEPTH and WIDTH (64):
  - synchronous clear, push/pop, full/empty/count.
  - Instantiated twice: the instruction FIFO (DEPTH) and the in-flight PC queue (MAX_OUTSTANDING, WIDTH 32).

Test Plan:
- Reset then streaming: imem 1-cycle, always ready, returns word=addr^32'hA5A5_0000; decoder always ready -> pc_out sequence 0,4,8,... one per cycle from cycle 2 after reset deassertion, each instr_out matching.
- Decoder backpressure: hold instr_ready_in=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_req_valid_out=0 once fifo_count+outstanding=4, instr_out stable; release -> PCs 0..C then 10 with no gap or duplicate.
- Redirect with 2 in flight: 3-cycle memory latency, redirect to 32'h0000_0103 -> both stale responses dropped; first delivered pc_out=32'h0000_0100, next 0x104.
- Redirect coincident with response and pop: redirect while FIFO holds 2 entries -> FIFO empty next cycle; no stale PC appears at any later instr_valid_out.
- PC wrap: RESET_PC=32'hFFFF_FFF8 -> pc_out FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-operation: assert reset with 3 buffered and 1 outstanding -> next cycle instr_valid_out=0, imem_addr_out=RESET_PC; refetch starts from RESET_PC.
